// File: rtl/fpu_multiplication_function.sv
// IEEE-754 multiplier (W=32 single, W=64 double) driven by a fixed-sequence FSM with start/ready handshake.
// Optional build macro FPU_MUL_ZERO_BYPASS_EN: zero/denormal operands jump from ZERO_CHK straight to DONE.
module fpu_multiplication_function #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         beg_FSM,
  input  logic         rst_FSM,
  input  logic [W-1:0] Data_MX,
  input  logic [W-1:0] Data_MY,
  input  logic [1:0]   round_mode,
  output logic         overflow_flag,
  output logic         underflow_flag,
  output logic         ready_flag,
  output logic [W-1:0] F_ieee_result
);
  localparam int EW = (W == 64) ? 11 : 8;
  localparam int FW = W - 1 - EW;
  localparam int MW = FW + 1;
  localparam int PW = 2 * MW;
  localparam int XW = EW + 2;
  localparam logic signed [XW-1:0] BIAS  = XW'((1 << (EW - 1)) - 1);
  localparam logic signed [XW-1:0] EMAX  = XW'((1 << EW) - 1);
  localparam logic signed [XW-1:0] EZERO = '0;

  typedef enum logic [2:0] {IDLE, LOAD, ZERO_CHK, MULT, NORM, ROUND, PACK, DONE} state_t;
  state_t r_state, w_next;

  logic [W-1:0]         r_x, r_y, r_result;
  logic [1:0]           r_rm;
  logic [PW-1:0]        r_prod;
  logic signed [XW-1:0] r_exp;
  logic [FW-1:0]        r_frac;
  logic                 r_ovf, r_unf, r_ready;

  logic                 w_sign, w_zero, w_inf;
  logic [EW-1:0]        w_ex, w_ey;
  logic signed [XW-1:0] w_exp_sum;
  logic [PW-1:0]        w_norm;
  logic [FW-1:0]        w_frac, w_rfrac;
  logic                 w_guard, w_sticky, w_inc, w_carry;

  assign w_sign    = r_x[W-1] ^ r_y[W-1];
  assign w_ex      = r_x[W-2:FW];
  assign w_ey      = r_y[W-2:FW];
  assign w_zero    = (w_ex == '0) | (w_ey == '0);
  assign w_inf     = (&w_ex) | (&w_ey);
  assign w_exp_sum = $signed({2'b00, w_ex}) + $signed({2'b00, w_ey}) - BIAS;

  // Bit shifted out by normalization is jammed into the LSB so sticky stays exact.
  assign w_norm   = r_prod[PW-1] ? {1'b0, r_prod[PW-1:2], |r_prod[1:0]} : r_prod;
  assign w_frac   = r_prod[PW-3 -: FW];
  assign w_guard  = r_prod[MW-2];
  assign w_sticky = |r_prod[MW-3:0];

  always_comb begin
    w_inc = 1'b0;
    case (r_rm)
      2'b00:   w_inc = w_guard & (w_sticky | w_frac[0]);
      2'b01:   w_inc = (w_guard | w_sticky) & ~w_sign;
      2'b10:   w_inc = (w_guard | w_sticky) & w_sign;
      default: w_inc = 1'b0;
    endcase
  end

  // Carry out of the fraction means the significand rolled over to 10.000..: fraction 0, E+1.
  assign {w_carry, w_rfrac} = {1'b0, w_frac} + (FW + 1)'(w_inc);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     if (beg_FSM) w_next = LOAD;
      LOAD:     w_next = ZERO_CHK;
`ifdef FPU_MUL_ZERO_BYPASS_EN
      ZERO_CHK: w_next = w_zero ? DONE : MULT;
`else
      ZERO_CHK: w_next = MULT;
`endif
      MULT:     w_next = NORM;
      NORM:     w_next = ROUND;
      ROUND:    w_next = PACK;
      PACK:     w_next = DONE;
      DONE:     w_next = DONE;
      default:  w_next = IDLE;
    endcase
    if (rst_FSM) w_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x      <= '0;
      r_y      <= '0;
      r_rm     <= '0;
      r_prod   <= '0;
      r_exp    <= '0;
      r_frac   <= '0;
      r_result <= '0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
      r_ready  <= 1'b0;
    end else begin
      // PACK raises ready alongside the result; DONE holds it (and raises it on the bypass path).
      r_ready <= ~rst_FSM & ((r_state == PACK) | (r_state == DONE));
      if (!rst_FSM) begin
        case (r_state)
          LOAD: begin
            r_x   <= Data_MX;
            r_y   <= Data_MY;
            r_rm  <= round_mode;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
          end
          ZERO_CHK: begin
`ifdef FPU_MUL_ZERO_BYPASS_EN
            if (w_zero) r_result <= {w_sign, {(W-1){1'b0}}};
`endif
          end
          MULT: begin
            r_prod <= PW'({1'b1, r_x[FW-1:0]}) * PW'({1'b1, r_y[FW-1:0]});
            r_exp  <= w_exp_sum;
          end
          NORM: begin
            r_prod <= w_norm;
            r_exp  <= r_exp + $signed({{(XW-1){1'b0}}, r_prod[PW-1]});
          end
          ROUND: begin
            r_frac <= w_carry ? '0 : w_rfrac;
            r_exp  <= r_exp + $signed({{(XW-1){1'b0}}, w_carry});
          end
          PACK: begin
            if (w_zero) begin
              r_result <= {w_sign, {(W-1){1'b0}}};
            end else if (w_inf || (r_exp >= EMAX)) begin
              r_result <= {w_sign, {EW{1'b1}}, {FW{1'b0}}};
              r_ovf    <= 1'b1;
            end else if (r_exp <= EZERO) begin
              r_result <= {w_sign, {(W-1){1'b0}}};
              r_unf    <= 1'b1;
            end else begin
              r_result <= {w_sign, r_exp[EW-1:0], r_frac};
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign overflow_flag  = r_ovf;
  assign underflow_flag = r_unf;
  assign ready_flag     = r_ready;
  assign F_ieee_result  = r_result;
endmodule

// File: tb/tb_fpu_multiplication_function.sv
// Self-checking bench for fpu_multiplication_function (W=32): directed cases, handshake, random vs. exact model.
module tb_fpu_multiplication_function;
  logic        clk = 1'b0;
  logic        rst, beg_FSM, rst_FSM;
  logic [31:0] Data_MX, Data_MY;
  logic [1:0]  round_mode;
  logic        overflow_flag, underflow_flag, ready_flag;
  logic [31:0] F_ieee_result;

  int total = 0;
  int bad   = 0;

`ifdef FPU_MUL_ZERO_BYPASS_EN
  localparam int ZLAT = 3;
`else
  localparam int ZLAT = 6;
`endif

  always #5 clk = ~clk;

  fpu_multiplication_function #(.W(32)) dut (
    .clk(clk), .rst(rst), .beg_FSM(beg_FSM), .rst_FSM(rst_FSM),
    .Data_MX(Data_MX), .Data_MY(Data_MY), .round_mode(round_mode),
    .overflow_flag(overflow_flag), .underflow_flag(underflow_flag),
    .ready_flag(ready_flag), .F_ieee_result(F_ieee_result)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Exact reference: integer product, remainder-based rounding, then range checks.
  function automatic void model(input logic [31:0] x, input logic [31:0] y, input logic [1:0] rm,
                                output logic [31:0] r, output logic ov, output logic un);
    logic s, up;
    int ex, ey, e, sh;
    logic [63:0] p, q, rem, half;
    s  = x[31] ^ y[31];
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    ov = 1'b0;
    un = 1'b0;
    r  = '0;
    if (ex == 0 || ey == 0) begin
      r = {s, 31'b0};
    end else if (ex == 255 || ey == 255) begin
      r = {s, 8'hFF, 23'b0};
      ov = 1'b1;
    end else begin
      p  = {40'b0, 1'b1, x[22:0]} * {40'b0, 1'b1, y[22:0]};
      e  = ex + ey - 127;
      sh = 23;
      if (p >= (64'd1 << 47)) begin sh = 24; e++; end
      q    = p >> sh;
      rem  = p - (q << sh);
      half = 64'd1 << (sh - 1);
      case (rm)
        2'd0:    up = (rem > half) || (rem == half && q[0]);
        2'd1:    up = (rem != 0) && !s;
        2'd2:    up = (rem != 0) && s;
        default: up = 1'b0;
      endcase
      q = q + 64'(up);
      if (q == (64'd1 << 24)) begin q = q >> 1; e++; end
      if (e >= 255) begin
        r = {s, 8'hFF, 23'b0};
        ov = 1'b1;
      end else if (e <= 0) begin
        r = {s, 31'b0};
        un = 1'b1;
      end else begin
        r = {s, 8'(e), q[22:0]};
      end
    end
  endfunction

  function automatic logic [31:0] rand_op();
    logic [7:0]  e;
    logic [22:0] f;
    int pick;
    pick = int'($urandom_range(0, 11));
    if (pick == 0)      e = 8'h00;
    else if (pick == 1) e = 8'hFF;
    else if (pick <= 4) e = 8'($urandom_range(1, 254));
    else                e = 8'($urandom_range(100, 154));
    f = 23'($urandom);
    if ($urandom_range(0, 3) == 0) f = f & 23'h7FF000;
    return {1'($urandom), e, f};
  endfunction

  // Full transaction: start, wait for ready (bounded), check, acknowledge, check hold.
  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic [1:0] rm,
                        input logic [31:0] er, input logic eo, input logic eu, input string tag);
    int lat;
    int exp_lat;
    exp_lat = (x[30:23] == 8'h00 || y[30:23] == 8'h00) ? ZLAT : 6;
    @(posedge clk); #1;
    Data_MX = x; Data_MY = y; round_mode = rm; beg_FSM = 1'b1;
    @(posedge clk); #1;
    beg_FSM = 1'b0;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (n == 1) begin
        Data_MX = $urandom; Data_MY = $urandom; round_mode = 2'($urandom);
      end
      if (ready_flag) begin lat = n; break; end
    end
    check({tag, "/latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "/result"}, 64'(F_ieee_result), 64'(er));
    check({tag, "/ovf"}, 64'(overflow_flag), 64'(eo));
    check({tag, "/unf"}, 64'(underflow_flag), 64'(eu));
    rst_FSM = 1'b1;
    @(posedge clk); #1;
    rst_FSM = 1'b0;
    check({tag, "/ready_ack"}, 64'(ready_flag), 64'd0);
    check({tag, "/result_hold"}, 64'(F_ieee_result), 64'(er));
  endtask

  initial begin
    logic [31:0] mr;
    logic        mo, mu;
    int          lat;
    rst = 1'b1; beg_FSM = 1'b0; rst_FSM = 1'b0;
    Data_MX = '0; Data_MY = '0; round_mode = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset/result", 64'(F_ieee_result), 64'd0);
    check("reset/ready", 64'(ready_flag), 64'd0);
    check("reset/ovf", 64'(overflow_flag), 64'd0);
    check("reset/unf", 64'(underflow_flag), 64'd0);
    rst = 1'b0;

    run_op(32'h40400000, 32'h40000000, 2'd0, 32'h40C00000, 1'b0, 1'b0, "3x2");
    run_op(32'h3FC00000, 32'hC0200000, 2'd0, 32'hC0700000, 1'b0, 1'b0, "1.5x-2.5");
    run_op(32'h80000000, 32'h3F800000, 2'd0, 32'h80000000, 1'b0, 1'b0, "negzero");
    for (int m = 0; m < 4; m++)
      run_op(32'h3F800001, 32'h3F800001, 2'(m), (m == 1) ? 32'h3F800003 : 32'h3F800002,
             1'b0, 1'b0, "round_ulp");
    run_op(32'h7F000000, 32'h7F000000, 2'd0, 32'h7F800000, 1'b1, 1'b0, "overflow");
    check("ovf_held_after_ack", 64'(overflow_flag), 64'd1);

    // Abort in MULT: result holds, flags were cleared by LOAD, no ready appears.
    @(posedge clk); #1;
    Data_MX = 32'h40400000; Data_MY = 32'h40000000; round_mode = 2'd0; beg_FSM = 1'b1;
    @(posedge clk); #1; beg_FSM = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1; rst_FSM = 1'b1;
    @(posedge clk); #1; rst_FSM = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("abort/ready", 64'(ready_flag), 64'd0);
    check("abort/result_hold", 64'(F_ieee_result), 64'h7F800000);
    check("abort/ovf_cleared", 64'(overflow_flag), 64'd0);
    run_op(32'h00800000, 32'h00800000, 2'd0, 32'h00000000, 1'b0, 1'b1, "underflow");

    // beg_FSM held high throughout the run and while in DONE.
    @(posedge clk); #1;
    Data_MX = 32'h40400000; Data_MY = 32'h40000000; round_mode = 2'd0; beg_FSM = 1'b1;
    lat = 0;
    for (int n = 0; n <= 20; n++) begin
      @(posedge clk); #1;
      if (ready_flag) begin lat = n; break; end
    end
    check("beg_held/latency", 64'(lat), 64'd6);
    check("beg_held/result", 64'(F_ieee_result), 64'h40C00000);
    repeat (3) @(posedge clk);
    #1;
    check("beg_held/ready_stays", 64'(ready_flag), 64'd1);
    check("beg_held/result_stays", 64'(F_ieee_result), 64'h40C00000);
    beg_FSM = 1'b0; rst_FSM = 1'b1;
    @(posedge clk); #1; rst_FSM = 1'b0;
    check("beg_held/ready_ack", 64'(ready_flag), 64'd0);

    // Global reset in the middle of an operation clears every output.
    @(posedge clk); #1;
    Data_MX = 32'h7F000000; Data_MY = 32'h7F000000; beg_FSM = 1'b1;
    @(posedge clk); #1; beg_FSM = 1'b0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    check("midrst/result", 64'(F_ieee_result), 64'd0);
    check("midrst/ready", 64'(ready_flag), 64'd0);
    check("midrst/ovf", 64'(overflow_flag), 64'd0);
    repeat (8) @(posedge clk);
    #1;
    check("midrst/idle", 64'(ready_flag), 64'd0);

    for (int i = 0; i < 150; i++) begin
      logic [31:0] x, y;
      logic [1:0]  rm;
      x  = rand_op();
      y  = rand_op();
      rm = 2'($urandom);
      model(x, y, rm, mr, mo, mu);
      run_op(x, y, rm, mr, mo, mu, "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
